// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM encoding, requester count, index/counter widths and the grant decoder.
package rr_arbiter4_pkg;

  localparam int unsigned REQ_N = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // 2-to-4 one-hot decode of a requester index
  function automatic logic [REQ_N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return REQ_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master side drives req/done; the slave side (arbiter) returns the grant.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic [REQ_N-1:0] req;
  logic [REQ_N-1:0] done;
  logic [REQ_N-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after `last`, wrapping.
// Scan order is last+1, last+2, last+3, last (all modulo 4).
module rr_pick
  import rr_arbiter4_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_valid
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest candidate wins.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = int'(REQ_N); k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        pick_idx   = cand;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a hold-time limit and forced revoke.
// IDLE picks the next requester; BUSY holds the grant until done, request drop or timeout.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         CLK,
  input  logic         Reset,
  rr_arbiter4_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [IDX_W-1:0] last_q,      last_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [REQ_N-1:0] gnt_q,       gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q,   timeout_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             holder_done_c;
  logic             holder_req_c;
  logic             at_max_c;

  rr_pick u_pick (
    .req        (bus.req),
    .last       (last_q),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign holder_done_c = bus.done[idx_q];
  assign holder_req_c  = bus.req[idx_q];
  assign at_max_c      = (cnt_q == HOLD_MAX);

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_BUSY;
          idx_d       = pick_idx;
          cnt_d       = CNT_W'(1);
          gnt_d       = idx_to_onehot(pick_idx);
          gnt_valid_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (holder_done_c || !holder_req_c || at_max_c) begin
          state_d     = ST_IDLE;
          last_d      = idx_q;
          cnt_d       = '0;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // A release via done on the limit edge is not a forced revoke.
          timeout_d   = at_max_c && !holder_done_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset parks last at 3 so requester 0 has first priority.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= IDX_W'(REQ_N - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive cycles one grant is held before forced revoke; legal range 2..255.
REQ-002 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port Reset, input, 1: asynchronous, active-high reset.
REQ-004 Port req, input, 4: request vector; bit i is requester i.
REQ-005 Port done, input, 4: release strobe; bit i is sampled only while requester i holds the grant.
REQ-006 Port gnt, output, 4: one-hot grant vector; all-zero when no grant.
REQ-007 Port gnt_idx, output, 2: binary index of the current or most recent winner.
REQ-008 Port gnt_valid, output, 1: high whenever gnt is nonzero.
REQ-009 Port timeout, output, 1: one-cycle pulse on a forced revoke.

Function
REQ-010 Two-state FSM, IDLE and BUSY, shall be used.
REQ-011 IDLE with req != 0: pick the first set req bit scanning (last+1), (last+2), (last+3), last mod 4; register it as gnt_idx; enter BUSY.
REQ-012 gnt shall be the 2-to-4 one-hot decode of gnt_idx, qualified by state == BUSY.
REQ-013 Grant latency: gnt shall assert on the first clock edge after req is sampled in IDLE, i.e. one cycle.
REQ-014 IDLE with req == 0: remain in IDLE; gnt = 0; gnt_idx and last unchanged.
REQ-015 BUSY: hold counter increments by 1 each cycle, starting at 1 on the first BUSY cycle.
REQ-016 BUSY exits to IDLE on the edge where any of these holds: done[gnt_idx]; req[gnt_idx] == 0; hold counter == MAX_HOLD.
REQ-017 On every BUSY exit, last shall be set to gnt_idx and the hold counter cleared.
REQ-018 gnt shall deassert in the cycle following the exit condition.
REQ-019 At least one IDLE cycle separates consecutive grants, including back-to-back re-grant to the same requester.
REQ-020 timeout shall pulse high for exactly one cycle, coincident with the first IDLE cycle, only when the exit cause is hold counter == MAX_HOLD.
REQ-021 When done[gnt_idx] and the MAX_HOLD limit occur on the same edge, done takes precedence and timeout shall stay low.
REQ-022 done bits of non-holding requesters shall be ignored.
REQ-023 req bits of non-holding requesters shall not alter the current grant.
REQ-024 Round-robin fairness: with all four req bits held high and done pulsed once per grant, grants shall rotate 0,1,2,3,0,...
REQ-025 gnt shall never have more than one bit set.

Reset
REQ-026 On Reset assertion, immediately and regardless of CLK: state = IDLE, gnt = 0000, gnt_valid = 0, gnt_idx = 00, timeout = 0, hold counter = 0, last = 3 (requester 0 has first priority).
REQ-027 Reset asserted during BUSY shall drop the grant without a timeout pulse and without updating last beyond its reset value.
REQ-028 The first arbitration shall occur on the first rising CLK edge after Reset deasserts.

Structure
REQ-029 A shared package shall hold: the FSM state encoding (IDLE, BUSY), the requester count constant (4), and the index width constant (2).
REQ-030 One sub-module, rr_pick, shall be used: combinational; inputs req[3:0] and last[1:0]; outputs pick_idx[1:0] and pick_valid.
REQ-031 The counter width shall be 8 bits.

Verification
REQ-032 Reset, then req = 0001 -> gnt = 0001 one cycle later; done[0] pulse -> gnt = 0000 on the next cycle; timeout = 0.
REQ-033 req = 1111 held, done pulsed each grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, separated by single IDLE cycles.
REQ-034 req = 0100 held, done never asserted, MAX_HOLD = 16 -> gnt = 0100 for exactly 16 cycles, then gnt = 0000 and timeout = 1 for one cycle, then re-grant to 0100.
REQ-035 Holder 1, done = 1010 -> only done[1] releases; with req = 1001 pending the next grant goes to 3, not 0.
REQ-036 done[gnt_idx] on the same edge the counter reaches MAX_HOLD -> release with timeout = 0.
REQ-037 Reset asserted mid-BUSY, between clock edges -> gnt = 0000 immediately; after release, req = 1111 grants requester 0 first.
